// File: rtl/rand_sched.sv
// Round-robin scheduler sharing one LFSR among NREQ requesters; each grant steps the LFSR.
// Optional RAND_SCHED_NOREPEAT_EN re-draws (up to 3 times) a value equal to the requester's last.
module rand_sched #(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned STEP_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  output logic [WIDTH-1:0] rand_out,
  output logic             busy,
  output logic             lfsr_en,
  input  logic [WIDTH-1:0] lfsr_data
);

  localparam int unsigned   PW      = $clog2(NREQ);
  localparam logic [3:0]    CntLoad = 4'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] LastIdx = PW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StStep, StGrant} state_e;

  state_e           state_q;
  logic [PW-1:0]    ptr_q, win_q, win_d;
  logic [3:0]       cnt_q;
  logic [NREQ-1:0]  ack_q;
  logic [WIDTH-1:0] rand_q;
  logic             busy_q, en_q;
  logic             any_req, redraw;
  int unsigned      idx;

  // First set request at or above ptr_q, wrapping past NREQ-1.
  always_comb begin
    win_d   = ptr_q;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win_d   = PW'(idx);
      end
    end
  end

`ifdef RAND_SCHED_NOREPEAT_EN
  logic [WIDTH-1:0] hist_q [NREQ];
  logic [1:0]       redraw_q;

  assign redraw = (lfsr_data == hist_q[win_q]) && (redraw_q != 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redraw_q <= '0;
      for (int i = 0; i < int'(NREQ); i++) hist_q[i] <= '0;
    end else if (state_q == StGrant) begin
      if (redraw) begin
        redraw_q <= redraw_q + 2'd1;
      end else begin
        redraw_q <= '0;
        if (req[win_q]) hist_q[win_q] <= lfsr_data;
      end
    end
  end
`else
  assign redraw = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rand_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            win_q   <= win_d;
            cnt_q   <= CntLoad;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StStep;
          end
        end
        StStep: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            en_q    <= 1'b0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (redraw) begin
            cnt_q   <= CntLoad;
            en_q    <= 1'b1;
            state_q <= StStep;
          end else begin
            // A dropped request still consumes the draw and advances the pointer.
            rand_q  <= lfsr_data;
            ack_q   <= req[win_q] ? (NREQ'(1) << win_q) : '0;
            ptr_q   <= (win_q == LastIdx) ? '0 : win_q + 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack      = ack_q;
  assign rand_out = rand_q;
  assign busy     = busy_q;
  assign lfsr_en  = en_q;

endmodule

// File: tb/tb_rand_sched.sv
// Self-checking bench for rand_sched: directed tables, hand sequences and a randomized model check.
module tb_rand_sched;
  localparam int unsigned NREQ = 3;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned STEP = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  ack;
  logic [WIDTH-1:0] rand_out;
  logic             busy, lfsr_en;
  logic [WIDTH-1:0] lfsr_data;
  logic [WIDTH-1:0] stub_q;
  logic             stub_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  rand_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .STEP_CYCLES(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .rand_out  (rand_out),
    .busy      (busy),
    .lfsr_en   (lfsr_en),
    .lfsr_data (lfsr_data)
  );

  always #5 clk = ~clk;

  // LFSR stand-in: a counter advanced by lfsr_en.
  always_ff @(posedge clk) begin
    if (stub_clr) stub_q <= '0;
    else if (lfsr_en) stub_q <= stub_q + 5'd1;
  end

`ifdef RAND_SCHED_NOREPEAT_EN
  assign lfsr_data = 5'd7;
`else
  assign lfsr_data = stub_q;
`endif

  typedef struct {
    logic [2:0] req;
    logic [2:0] exp_ack;
    logic [4:0] exp_rand;
    int         exp_gap;
  } vec_t;

  vec_t fair_tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req      = '0;
    rst      = 1'b1;
    stub_clr = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    stub_clr = 1'b0;
  endtask

  task automatic wait_ack(input int limit, output int n, output logic [2:0] a);
    n = 0;
    a = '0;
    while (n < limit) begin
      tick();
      n++;
      if (ack != '0) begin
        a = ack;
        break;
      end
    end
  endtask

  function automatic int rr(input logic [2:0] r, input int p);
    for (int i = 0; i < int'(NREQ); i++) begin
      int k;
      k = (p + i) % int'(NREQ);
      if (r[k]) return k;
    end
    return p;
  endfunction

  // Transaction-level model state
  int         m_ptr, m_win, m_timer;
  logic [4:0] m_lfsr, m_rand;
  logic [2:0] m_ack;

  task automatic model_edge(input logic [2:0] r);
    m_ack = '0;
    if (m_timer == 0) begin
      if (r != '0) begin
        m_win   = rr(r, m_ptr);
        m_timer = STEP + 1;
        m_lfsr  = m_lfsr + 5'(STEP);
      end
    end else begin
      m_timer--;
      if (m_timer == 0) begin
        m_rand = m_lfsr;
        if (r[m_win]) m_ack = 3'(1 << m_win);
        m_ptr = (m_win + 1) % int'(NREQ);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, en_cnt;
    logic [2:0] a;

    fair_tbl[0] = '{req: 3'b111, exp_ack: 3'b001, exp_rand: 5'd5,  exp_gap: 7};
    fair_tbl[1] = '{req: 3'b111, exp_ack: 3'b010, exp_rand: 5'd10, exp_gap: 7};
    fair_tbl[2] = '{req: 3'b111, exp_ack: 3'b100, exp_rand: 5'd15, exp_gap: 7};
    fair_tbl[3] = '{req: 3'b111, exp_ack: 3'b001, exp_rand: 5'd20, exp_gap: 7};

    do_reset();
    chk("reset_ack", ack, 0);
    chk("reset_rand", rand_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_en", lfsr_en, 0);

`ifdef RAND_SCHED_NOREPEAT_EN
    req = 3'b001;
    wait_ack(10, n, a);
    chk("nr_first_ack", a, 3'b001);
    chk("nr_first_lat", n, 7);
    chk("nr_first_rand", rand_out, 7);
    req = '0;
    tick();
    req = 3'b001;
    en_cnt = 0;
    n = 0;
    a = '0;
    while (n < 40) begin
      tick();
      n++;
      if (lfsr_en) en_cnt++;
      if (ack != '0) begin
        a = ack;
        break;
      end
    end
    chk("nr_second_ack", a, 3'b001);
    chk("nr_second_lat", n, 25);
    chk("nr_second_en", en_cnt, 20);
    chk("nr_second_rand", rand_out, 7);
    req = '0;
`else
    // Single request: timing of lfsr_en, busy, ack and rand_out
    req = 3'b001;
    en_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (lfsr_en) en_cnt++;
      if (k == 1) chk("single_en_start", lfsr_en, 1);
      if (k == 6) begin
        chk("single_en_stop", lfsr_en, 0);
        chk("single_busy_grant", busy, 1);
        chk("single_no_early_ack", ack, 0);
      end
      if (k == 7) begin
        chk("single_ack", ack, 3'b001);
        chk("single_rand", rand_out, 5);
        chk("single_busy_done", busy, 0);
      end
    end
    chk("single_en_count", en_cnt, 5);
    req = '0;
    tick();
    chk("single_ack_pulse", ack, 0);

    // Fairness table
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = fair_tbl[i].req;
      wait_ack(20, n, a);
      chk($sformatf("fair%0d_ack", i), a, fair_tbl[i].exp_ack);
      chk($sformatf("fair%0d_gap", i), n, fair_tbl[i].exp_gap);
      chk($sformatf("fair%0d_rand", i), rand_out, fair_tbl[i].exp_rand);
    end
    req = '0;

    // Dropped request
    do_reset();
    req = 3'b010;
    tick();
    tick();
    tick();
    req = '0;
    wait_ack(8, n, a);
    chk("drop_noack", a, 0);
    chk("drop_rand", rand_out, 5);
    req = 3'b011;
    wait_ack(10, n, a);
    chk("drop_next_ack", a, 3'b001);
    chk("drop_next_rand", rand_out, 10);
    req = 3'b010;
    wait_ack(10, n, a);
    chk("drop_then_ack", a, 3'b010);
    chk("drop_then_rand", rand_out, 15);
    req = '0;

    // Asynchronous reset in the middle of a draw
    do_reset();
    req = 3'b001;
    wait_ack(10, n, a);
    chk("rst_pre_ack", a, 3'b001);
    tick();
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_ack", ack, 0);
    chk("rst_async_rand", rand_out, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_en", lfsr_en, 0);
    req = '0;
    tick();
    chk("rst_en_held", lfsr_en, 0);
    rst = 1'b0;
    wait_ack(8, n, a);
    chk("rst_noack", a, 0);
    chk("rst_lfsr_frozen", stub_q, 7);
    req = 3'b001;
    wait_ack(10, n, a);
    chk("rst_after_ack", a, 3'b001);
    chk("rst_after_lat", n, 7);
    chk("rst_after_rand", rand_out, 12);
    req = '0;

    // Randomized traffic against the transaction model
    do_reset();
    m_ptr   = 0;
    m_win   = 0;
    m_timer = 0;
    m_lfsr  = '0;
    m_rand  = '0;
    m_ack   = '0;
    for (int c = 0; c < 1500; c++) begin
      logic [2:0] nr;
      nr = req;
      for (int b = 0; b < int'(NREQ); b++) begin
        if (req[b] && ack[b]) nr[b] = ($urandom_range(3) == 0);
        else if (req[b]) nr[b] = ($urandom_range(39) != 0);
        else nr[b] = ($urandom_range(3) == 0);
      end
      req = nr;
      tick();
      model_edge(req);
      chk("rnd_ack", ack, m_ack);
      chk("rnd_rand", rand_out, m_rand);
      chk("rnd_busy", busy, m_timer >= 1);
      chk("rnd_en", lfsr_en, m_timer >= 2);
    end
    req = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
